// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS core.
//   XLEN             : datapath / address width
//   INSTR_BYTES      : bytes per instruction word (PC stride)
//   RESET_PC_DEFAULT : default fetch address after reset
//   fetch_entry_t    : one prefetch-queue entry, {pc, instr}
//   word_align()     : clears the byte-offset bits of an address
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Bundle of the fetch stage's bus signals.
//   imem_*  : request/response to the 1-cycle synchronous instruction ROM
//   out_*   : valid/ready delivery of {instr, pc, pc+4} to decode
//   redir_* : redirect strobe and target from decode, misalign pulse back
//   queue_count : prefetch queue occupancy
// Modport master is the fetch stage, slave is its environment (ROM + decode).
interface ifetch_prefetch_if #(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int DEPTH = 4
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic [XLEN-1:0]  imem_rdata;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_instr;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_link_addr;

  logic             redir_valid;
  logic [XLEN-1:0]  redir_target;
  logic             redir_misaligned;

  logic [CNT_W-1:0] queue_count;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    output out_valid, out_instr, out_pc, out_link_addr,
    input  out_ready,
    input  redir_valid, redir_target,
    output redir_misaligned,
    output queue_count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    input  out_valid, out_instr, out_pc, out_link_addr,
    output out_ready,
    output redir_valid, redir_target,
    input  redir_misaligned,
    input  queue_count
  );

endinterface

// File: rtl/ifetch_prefetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t with push, pop and flush.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empties the queue (wins over push/pop)
//   push_i/entry_i: write entry at tail
//   pop_i         : drop head (ignored when empty)
//   head_o        : current head entry (undefined when empty)
//   count_o       : occupancy 0..DEPTH
//   empty_o       : count_o == 0
// Pointers are clog2(DEPTH) bits and wrap naturally; the separate count keeps
// full and empty unambiguous.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             entry_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a push into a full queue needs.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: PC owner and prefetching fetch stage.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : ifetch_prefetch_if.master (ROM request/response, decode
//           valid/ready delivery, redirect input, misalign pulse, occupancy)
// A request goes out whenever the queue plus the in-flight word still fit,
// so returned words always have room. Each request is tagged with the
// current epoch; a redirect toggles the epoch and flushes the queue, so a
// stale word returning afterwards fails the tag match and is dropped.
module ifetch_prefetch #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  ifetch_prefetch_if.master  bus
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [XLEN-1:0]  STEP    = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  req_pc_q,   req_pc_d;
  logic             inflight_q, inflight_d;
  logic             tag_q,      tag_d;
  logic             epoch_q,    epoch_d;
  logic             misalign_q, misalign_d;

  logic             issue;
  logic             push;
  logic             pop;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pending;
  fetch_entry_t     entry_in;
  fetch_entry_t     head;

  // ---- issue: credit check against queue occupancy plus in-flight word
  assign pending = count + {{(CNT_W-1){1'b0}}, inflight_q};
  // Gated by reset so no request is presented while reset is asserted.
  assign issue   = reset && !bus.redir_valid && (pending < DEPTH_C);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    tag_d      = tag_q;
    epoch_d    = epoch_q;
    misalign_d = 1'b0;
    if (bus.redir_valid) begin
      fetch_pc_d = word_align(bus.redir_target);
      epoch_d    = ~epoch_q;
      misalign_d = |bus.redir_target[1:0];
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + STEP;
      req_pc_d   = fetch_pc_q;
      inflight_d = 1'b1;
      tag_d      = epoch_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
      epoch_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      epoch_q    <= epoch_d;
      misalign_q <= misalign_d;
    end
  end

  // Address of the word in flight; meaningful only while inflight_q is set.
  always_ff @(posedge clock) begin
    req_pc_q <= req_pc_d;
  end

  // ---- return: ROM word lands in the queue if still current
  assign push = inflight_q && (tag_q == epoch_q) && !bus.redir_valid;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    entry_in.pc    = req_pc_q;
    entry_in.instr = bus.imem_rdata;
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clock),
    .rst_ni  (reset),
    .flush_i (bus.redir_valid),
    .push_i  (push),
    .entry_i (entry_in),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty)
  );

  // ---- delivery: head of queue to decode, zeroed when empty
  assign bus.imem_req         = issue;
  assign bus.imem_addr        = fetch_pc_q;
  assign bus.out_valid        = !empty;
  assign bus.out_instr        = empty ? '0 : head.instr;
  assign bus.out_pc           = empty ? '0 : head.pc;
  assign bus.out_link_addr    = empty ? '0 : head.pc + STEP;
  assign bus.redir_misaligned = misalign_q;
  assign bus.queue_count      = count;

endmodule

// File: tb/tb_ifetch_prefetch.sv
module tb_ifetch_prefetch;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] exp_q[$];
  logic [31:0] exp_w[$];
  logic [31:0] mon_pc;
  logic [31:0] mon_pc_w;
  logic        wrap_done;

  ifetch_prefetch_if #(.XLEN(32), .DEPTH(4)) bus   ();
  ifetch_prefetch_if #(.XLEN(32), .DEPTH(4)) bus_w ();

  ifetch_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  ifetch_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clock (clock),
    .reset (reset),
    .bus   (bus_w)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return addr ^ 32'h2010_0001;
  endfunction

  // 1-cycle synchronous instruction ROMs
  always @(posedge clock) bus.imem_rdata   <= rom_word(bus.imem_addr);
  always @(posedge clock) bus_w.imem_rdata <= rom_word(bus_w.imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitors: every accepted head is compared with the next expected pc.
  always @(negedge clock) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc %h, required no delivery", bus.out_pc);
      end else begin
        mon_pc = exp_q.pop_front();
        check("out_pc",    bus.out_pc,        mon_pc);
        check("out_instr", bus.out_instr,     rom_word(mon_pc));
        check("out_link",  bus.out_link_addr, mon_pc + 32'd4);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && bus_w.out_valid && bus_w.out_ready) begin
      if (exp_w.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wrap_unexpected_out: got pc %h, required no delivery", bus_w.out_pc);
      end else begin
        mon_pc_w = exp_w.pop_front();
        check("wrap_out_pc",    bus_w.out_pc,        mon_pc_w);
        check("wrap_out_instr", bus_w.out_instr,     rom_word(mon_pc_w));
        check("wrap_out_link",  bus_w.out_link_addr, mon_pc_w + 32'd4);
      end
    end
  end

  // Wrap instance streams from reset with out_ready high until its list is consumed.
  initial begin
    wrap_done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clock);
      if (reset && exp_w.size() == 0) break;
    end
    #1;
    bus_w.out_ready = 1'b0;
    wrap_done = 1'b1;
  end

  task automatic drain_main(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clock);
      if (exp_q.size() == 0) break;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redir_valid    = 1'b0;
    bus.redir_target   = 32'h0;
    bus_w.out_ready    = 1'b1;
    bus_w.redir_valid  = 1'b0;
    bus_w.redir_target = 32'h0;
    exp_w.push_back(32'hFFFF_FFF8);
    exp_w.push_back(32'hFFFF_FFFC);
    exp_w.push_back(32'h0000_0000);
    exp_w.push_back(32'h0000_0004);
    exp_w.push_back(32'h0000_0008);

    // Reset held for three cycles
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 32'(bus.out_valid),        32'd0);
    check("rst_imem_req",  32'(bus.imem_req),         32'd0);
    check("rst_count",     32'(bus.queue_count),      32'd0);
    check("rst_misalign",  32'(bus.redir_misaligned), 32'd0);
    check("rst_out_pc",    bus.out_pc,                32'd0);
    check("rst_out_instr", bus.out_instr,             32'd0);
    check("rst_out_link",  bus.out_link_addr,         32'd0);
    check("rst_wrap_req",  32'(bus_w.imem_req),       32'd0);
    check("rst_wrap_cnt",  32'(bus_w.queue_count),    32'd0);
    check("rst_wrap_mis",  32'(bus_w.redir_misaligned), 32'd0);

    // Release: first request in the first cycle, word visible two cycles later
    reset = 1'b1;
    #1;
    check("first_req",       32'(bus.imem_req), 32'd1);
    check("first_addr",      bus.imem_addr,     32'h0);
    check("wrap_first_addr", bus_w.imem_addr,   32'hFFFF_FFF8);
    @(negedge clock);
    check("lat_not_early", 32'(bus.out_valid), 32'd0);
    check("second_addr",   bus.imem_addr,      32'h4);
    @(negedge clock);
    check("first_valid", 32'(bus.out_valid), 32'd1);
    check("first_pc",    bus.out_pc,         32'h0);
    check("first_link",  bus.out_link_addr,  32'h4);
    check("first_instr", bus.out_instr,      32'h2010_0001);

    // Backpressure: queue fills to DEPTH and requests stop, head held stable
    repeat (10) @(negedge clock);
    check("bp_count",    32'(bus.queue_count), 32'd4);
    check("bp_req",      32'(bus.imem_req),    32'd0);
    check("bp_valid",    32'(bus.out_valid),   32'd1);
    check("bp_pc_held",  bus.out_pc,           32'h0);

    // Streaming: four buffered pops then one per cycle, no gaps
    for (int i = 0; i < 24; i++) exp_q.push_back(32'(i * 4));
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      check("stream_no_gap", 32'(bus.out_valid), 32'd1);
      @(posedge clock);
      if (exp_q.size() == 0) break;
    end
    check("stream_done", 32'(exp_q.size()), 32'd0);
    #1;
    bus.out_ready = 1'b0;

    // Redirect to 0x08 with the queue holding stale words
    tick();
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h0000_0008;
    tick();
    bus.redir_valid = 1'b0;
    @(negedge clock);
    check("rdA_flush_cnt", 32'(bus.queue_count),      32'd0);
    check("rdA_flush_vld", 32'(bus.out_valid),        32'd0);
    check("rdA_req",       32'(bus.imem_req),         32'd1);
    check("rdA_addr",      bus.imem_addr,             32'h8);
    check("rdA_misalign",  32'(bus.redir_misaligned), 32'd0);
    tick();
    tick();
    @(negedge clock);
    check("rdA_t3_valid", 32'(bus.out_valid), 32'd1);
    check("rdA_t3_pc",    bus.out_pc,         32'h8);
    check("rdA_t3_addr",  bus.imem_addr,      32'h10);

    // Redirect to 0x40 while the 0x10 word is in flight
    tick();
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h0000_0040;
    @(negedge clock);
    check("rdB_no_req", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redir_valid = 1'b0;
    @(negedge clock);
    check("rdB_t1_cnt", 32'(bus.queue_count), 32'd0);
    check("rdB_t1_vld", 32'(bus.out_valid),   32'd0);
    tick();
    @(negedge clock);
    check("rdB_t2_vld", 32'(bus.out_valid), 32'd0);
    tick();
    @(negedge clock);
    check("rdB_t3_vld",   32'(bus.out_valid), 32'd1);
    check("rdB_t3_pc",    bus.out_pc,         32'h40);
    check("rdB_t3_instr", bus.out_instr,      rom_word(32'h40));

    // Redirect to 0x100 in the same cycle as a pop of 0x40
    tick();
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h0000_0100;
    bus.out_ready    = 1'b1;
    @(negedge clock);
    check("rdC_pop_pc", bus.out_pc, 32'h40);
    tick();
    bus.redir_valid = 1'b0;
    @(negedge clock);
    check("rdC_t1_vld", 32'(bus.out_valid), 32'd0);
    tick();
    tick();
    @(negedge clock);
    check("rdC_t3_vld", 32'(bus.out_valid), 32'd1);
    tick();
    tick();

    // Misaligned redirect to 0x43 while 0x108 is accepted
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    exp_q.push_back(32'h48);
    exp_q.push_back(32'h4C);
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h0000_0043;
    @(negedge clock);
    check("rdD_pop_pc", bus.out_pc, 32'h108);
    tick();
    bus.redir_valid = 1'b0;
    @(negedge clock);
    check("mis_pulse",  32'(bus.redir_misaligned), 32'd1);
    check("mis_cnt",    32'(bus.queue_count),      32'd0);
    check("mis_vld",    32'(bus.out_valid),        32'd0);
    check("mis_req",    32'(bus.imem_req),         32'd1);
    check("mis_addr",   bus.imem_addr,             32'h40);
    tick();
    @(negedge clock);
    check("mis_pulse_end", 32'(bus.redir_misaligned), 32'd0);
    tick();
    tick();
    tick();
    tick();

    // Back-to-back redirects 0x80 then 0xC0; 0x4C accepted in the first
    for (int i = 0; i < 6; i++) exp_q.push_back(32'hC0 + 32'(i * 4));
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h0000_0080;
    @(negedge clock);
    check("b2b_pop_pc", bus.out_pc, 32'h4C);
    tick();
    bus.redir_target = 32'h0000_00C0;
    @(negedge clock);
    check("b2b_t1_vld", 32'(bus.out_valid),        32'd0);
    check("b2b_t1_req", 32'(bus.imem_req),         32'd0);
    check("b2b_t1_mis", 32'(bus.redir_misaligned), 32'd0);
    tick();
    bus.redir_valid = 1'b0;
    @(negedge clock);
    check("b2b_addr", bus.imem_addr,     32'hC0);
    check("b2b_req",  32'(bus.imem_req), 32'd1);
    tick();
    @(negedge clock);
    check("b2b_t2_vld", 32'(bus.out_valid), 32'd0);
    tick();
    @(negedge clock);
    check("b2b_t3_vld", 32'(bus.out_valid), 32'd1);
    check("b2b_t3_pc",  bus.out_pc,         32'hC0);
    drain_main(100);

    for (int c = 0; c < 200; c++) begin
      if (wrap_done) break;
      @(posedge clock);
    end
    check("wrap_done", 32'(exp_w.size()), 32'd0);

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
- Parametrised fetch stage for the pipelined MIPS core; successor to the single-cycle Ifetc32.
- Owns the PC and issues word reads to a 1-cycle synchronous instruction ROM.
- Buffers returned words in a DEPTH-entry prefetch queue, delivered to decode over a valid/ready handshake.
- Redirects (branch/jump/jr) from decode flush the queue and discard in-flight stale data using an epoch bit.

Parameters:
- XLEN, 32: address and instruction width.
- DEPTH, 4: prefetch queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: PC loaded at reset.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- imem_req  out  1  read request this cycle.
- imem_addr  out  XLEN  word address; bits [1:0] are always 0.
- imem_rdata  in  XLEN  instruction for the request issued the previous cycle.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  XLEN  head instruction.
- out_pc  out  XLEN  PC of the head instruction.
- out_link_addr  out  XLEN  out_pc + 4 (branch base and jal link).
- redir_valid  in  1  decode redirect strobe.
- redir_target  in  XLEN  new PC (Addr_result, jump target or Read_data_1, already selected by decode).
- redir_misaligned  out  1  one-cycle pulse when redir_target[1:0] != 0.
- queue_count  out  clog2(DEPTH)+1  occupancy, for debug and perf counters.

Behaviour:
- Reset (async, reset == 0):
  - fetch_pc = RESET_PC, queue empty, no request in flight, epoch = 0.
  - Outputs: out_valid = 0, imem_req = 0, redir_misaligned = 0, queue_count = 0.
  - out_instr, out_pc and out_link_addr read 0.
- Issue rule:
  - imem_req = !redir_valid && (count + inflight + 0 < DEPTH), where inflight is 1 if a request was issued last cycle.
  - Credit counting guarantees no overflow, so returned data is never dropped for lack of space.
  - imem_addr = fetch_pc. On issue: fetch_pc <= fetch_pc + 4 (mod 2^XLEN; wraps from FFFF_FFFC to 0), inflight <= 1, tag <= epoch.
- Return: in the cycle after an issue, imem_rdata is written to the queue tail with {pc, instr} only if tag == epoch and no redirect occurs that cycle. Otherwise it is discarded.
- Latency:
  - Request issued in cycle N; word written at the end of cycle N+1; out_valid from cycle N+2.
  - After reset release, the first request goes out in the first clock; the instruction is visible two cycles later.
  - Steady-state throughput is 1 instruction/cycle with out_ready held high.
- Handshake:
  - Head pops when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - out_* are stable while out_valid && !out_ready.
- Redirect (redir_valid = 1 in cycle T):
  - Takes priority over everything. Queue is flushed (count = 0 at T+1) and epoch toggles.
  - fetch_pc <= {redir_target[XLEN-1:2], 2'b00}. No request is issued in T.
  - A handshake completing in T counts as consumed; the other entries are discarded.
  - Target request is issued at T+1; the target instruction has out_valid at T+3.
  - Back-to-back redirects: the last one wins, and each one toggles epoch.
- Misalign: redir_misaligned = 1 in cycle T+1 iff redir_target[1:0] != 0. The target is truncated, not trapped.
- Full queue (count == DEPTH): out_valid = 1, imem_req = 0 until a pop frees a credit.
- Pointers: clog2(DEPTH) bits, wrapping naturally; count is kept separately, so full and empty are unambiguous.
- Reset asserted mid-operation clears everything immediately; the in-flight return is ignored.

Decomposition:
- Shared package cpu_pkg holds XLEN, INSTR_BYTES = 4, RESET_PC_DEFAULT, and a fetch_entry_t struct {pc, instr}.
- One sub-module, fetch_queue: a parametrised synchronous FIFO with push, pop, flush and count, storing fetch_entry_t.
- PC, credit and epoch logic stay in ifetch_prefetch.

Test Plan:
- Reset: hold reset = 0 for 3 cycles, then release → imem_req = 1 with imem_addr = 0x0 in the first cycle. Return 0x2010_0001 → out_valid two cycles later with out_pc = 0, out_link_addr = 4.
- Streaming: out_ready = 1 and ROM[i] = i → one instruction per cycle in steady state, out_pc = 0, 4, 8, ..., no gaps after warm-up.
- Backpressure: out_ready = 0 for 10 cycles → queue_count saturates at 4 and imem_req falls to 0. Release → 4 pops, each with its correct pc, then streaming resumes with no loss or duplication.
- Redirect with in-flight data: redir_valid with target 0x0000_0040 while a request for 0x10 is in flight → the 0x10 word is discarded, queue flushed. Next out_pc = 0x40, at T+3.
- Misaligned redirect: target 0x0000_0043 → redir_misaligned pulses one cycle, fetch resumes at 0x40.
- Simultaneous events: redirect in the same cycle as a pop, and back-to-back redirects to 0x80 then 0xC0 → only 0xC0's stream is delivered. Also set RESET_PC = 0xFFFF_FFF8 → PC wraps to 0x0 after 0xFFFF_FFFC.
